pic_init_control: RTL and testbench
===================================

# pic_init_control

Write-side control stage of the 8259A-style interrupt controller, directly downstream of the `data_read` bus decoder. It synchronises the CPU write strobe and captures the data bus together with the decoder's `ICW`/`OCW` classification flags. It then runs the ICW1→ICW2→(ICW3)→(ICW4) initialisation sequence and holds the programmed configuration, the interrupt mask (OCW1) and the OCW2/OCW3 command fields used by the priority resolver and the read-back logic.

## Interface
Parameters: none.

Ports:
- `clk` input 1: system clock; everything is on its rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `WR` input 1: CPU write strobe, active-low, asynchronous to `clk`.
- `CS` input 1: chip select, active-low, asynchronous.
- `D` input 8: data bus, stable while `WR` is low.
- `ICW` input 2: from `data_read`. Bit0 = ICW1 pattern (A0=0, D4=1). Bit1 = A0=1 write.
- `OCW` input 3: from `data_read`. Bit0 = A0=1 write. Bit1 = OCW2 (A0=0, D4=0, D3=0). Bit2 = OCW3 (A0=0, D4=0, D3=1).
- `ready` output 1: initialisation complete.
- `ltim`, `sngl`, `ic4` output 1 each: ICW1 D3, D1, D0.
- `vector_base` output 5: ICW2 D7:3.
- `cascade` output 8: ICW3.
- `upm`, `aeoi`, `buf_mode`, `ms`, `sfnm` output 1 each: ICW4 D0, D1, D3, D2, D4.
- `imr` output 8: interrupt mask (OCW1).
- `ocw2_cmd` output 3: R, SL, EOI (D7:5) of the last OCW2.
- `ocw2_level` output 3: D2:0 of the last OCW2.
- `ocw2_stb` output 1: one-cycle pulse when an OCW2 is committed.
- `ris` output 1: read-register select. 0 = IRR, 1 = ISR.
- `smm` output 1: special mask mode.
- `poll_stb` output 1: one-cycle pulse on an OCW3 with P=1.

## Operation
- **Synchroniser.** `WR` and `CS` each pass through two flops (s1, s2). A third flop, `wr_s3`, holds the delayed write strobe.
- **Active write.** A write is active when `wr_s2`=0 and `cs_s2`=0.
  - On every clock of an active write, `D`, `ICW` and `OCW` are captured into holding registers. The last captured value wins.
  - An `active_seen` flag is set.
- **Commit.** A commit happens when `wr_s2`=1, `wr_s3`=0 and `active_seen`=1. `active_seen` clears on commit. A strobe with `CS` high never commits.
- **States:** UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY. `ready` = (state == READY).
- **Commit rules, in priority order:**
  1. ICW flag bit0 set, in any state:
     - Load `ltim`, `sngl`, `ic4`.
     - Clear `cascade`, all ICW4 fields, `imr`, `ris` and `smm`.
     - Go to WAIT_ICW2.
  2. WAIT_ICW2 with ICW flag bit1:
     - Load `vector_base`; D2:0 are ignored.
     - Next state: WAIT_ICW3 if `sngl`=0, else WAIT_ICW4 if `ic4`=1, else READY.
  3. WAIT_ICW3 with ICW flag bit1:
     - Load `cascade`.
     - Next state: WAIT_ICW4 if `ic4`=1, else READY.
  4. WAIT_ICW4 with ICW flag bit1: load the ICW4 fields, then go to READY.
  5. READY:
     - OCW flag bit0: `imr` ← D.
     - OCW flag bit1: load `ocw2_cmd` and `ocw2_level`; pulse `ocw2_stb`.
     - OCW flag bit2:
       - If D1 (RR) = 1, `ris` ← D0.
       - If D6 (ESMM) = 1, `smm` ← D5.
       - If D2 (P) = 1, pulse `poll_stb`.
  6. Any other commit is ignored with no state change. This includes A0=0 non-ICW1 writes outside READY.

## Timing
- **Reset values.** On reset, state = UNINIT. Every output and every holding register, synchroniser flop and `active_seen` resets to 0, except the `WR`/`CS` synchroniser flops, which reset to 1 so that no false edge occurs.
- **Reset priority.** Reset has priority over a commit in the same cycle. A reset in the middle of a sequence returns to UNINIT, and any pending commit is lost.
- **Latency.** Let edge k be the first `clk` edge that samples `WR` high. The commit is evaluated in the cycle after edge k+1. Registered outputs and the state update at edge k+2.
- **Strobes.** `ocw2_stb` and `poll_stb` are high for exactly the cycle after edge k+2. They are never asserted outside READY.
- **Minimum strobe widths.** `WR` must be low for at least 2 `clk` cycles and high for at least 2 `clk` cycles between writes. Shorter pulses may be missed, but must never produce a double commit.
- **Back-to-back commands.** Successive OCW2 commands each produce their own pulse.

## Test plan
- **Full init, single mode, no ICW4.** After reset, write ICW1=0x12 (`sngl`=1, `ic4`=0), then A0=1 0x48 → `ready`=1, `vector_base`=0x09, `cascade`=0x00, all ICW4 fields 0, `imr`=0x00.
- **Full init, cascade with ICW4.** Write ICW1=0x11, then 0x20, then 0x04, then 0x03 → states step WAIT_ICW2→WAIT_ICW3→WAIT_ICW4→READY; `cascade`=0x04, `upm`=1, `aeoi`=1.
- **OCW commands in READY.**
  - A0=1 write 0xA5 → `imr`=0xA5.
  - OCW2=0x63 → `ocw2_cmd`=3'b011, `ocw2_level`=3, `ocw2_stb` high for exactly one cycle.
  - OCW3=0x0B → `ris`=1.
  - OCW3=0x0C → `poll_stb` pulses once and `ris` stays 1.
- **Re-initialisation and early OCWs.**
  - In READY with `imr`=0xFF, write ICW1=0x13 → `imr`=0x00, `ris`=0, `ready`=0, state WAIT_ICW2.
  - An OCW2 written before ICW2 → no `ocw2_stb`.
- **Chip-select gating.** A `WR` pulse with `CS`=1 (value 0x12) → no state change.
- **Reset mid-sequence.** Assert `rst_n`=0 in WAIT_ICW3 → state UNINIT, all outputs 0. A following A0=1 write is ignored.

Source files
------------

// File: rtl/pic_init_control.sv
// pic_init_control: write-side control of an 8259A-style interrupt controller.
// Synchronises the CPU write strobe and captures the data bus with the decoder's
// ICW/OCW flags. Runs the ICW1..ICW4 initialisation sequence and holds the
// configuration, the interrupt mask and the OCW2/OCW3 command fields.
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   WR, CS            - asynchronous active-low write strobe / chip select
//   D, ICW, OCW       - data bus and write classification from data_read
//   ready             - initialisation complete
//   ltim/sngl/ic4, vector_base, cascade, upm/aeoi/buf_mode/ms/sfnm - ICW fields
//   imr               - interrupt mask (OCW1)
//   ocw2_cmd/level/stb - last OCW2 fields and commit pulse
//   ris, smm, poll_stb - OCW3 read select, special mask mode, poll pulse
module pic_init_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       WR,
    input  logic       CS,
    input  logic [7:0] D,
    input  logic [1:0] ICW,
    input  logic [2:0] OCW,
    output logic       ready,
    output logic       ltim,
    output logic       sngl,
    output logic       ic4,
    output logic [4:0] vector_base,
    output logic [7:0] cascade,
    output logic       upm,
    output logic       aeoi,
    output logic       buf_mode,
    output logic       ms,
    output logic       sfnm,
    output logic [7:0] imr,
    output logic [2:0] ocw2_cmd,
    output logic [2:0] ocw2_level,
    output logic       ocw2_stb,
    output logic       ris,
    output logic       smm,
    output logic       poll_stb
);

    typedef enum logic [2:0] {
        UNINIT    = 3'd0,
        WAIT_ICW2 = 3'd1,
        WAIT_ICW3 = 3'd2,
        WAIT_ICW4 = 3'd3,
        READY     = 3'd4
    } state_e;

    state_e     state_q, state_d;

    logic       wr_s1_q, wr_s2_q, wr_s3_q, cs_s1_q, cs_s2_q;
    logic       active_seen_q;
    logic [7:0] d_q;
    logic [1:0] icw_q;
    logic [2:0] ocw_q;

    logic       ltim_q, ltim_d, sngl_q, sngl_d, ic4_q, ic4_d;
    logic [4:0] vector_base_q, vector_base_d;
    logic [7:0] cascade_q, cascade_d;
    logic       upm_q, upm_d, aeoi_q, aeoi_d, buf_q, buf_d, ms_q, ms_d, sfnm_q, sfnm_d;
    logic [7:0] imr_q, imr_d;
    logic [2:0] ocw2_cmd_q, ocw2_cmd_d, ocw2_level_q, ocw2_level_d;
    logic       ocw2_stb_q, ocw2_stb_d, ris_q, ris_d, smm_q, smm_d, poll_stb_q, poll_stb_d;

    logic       active_c, commit_c;

    assign active_c = !wr_s2_q && !cs_s2_q;
    // Rising edge of the synchronised strobe closes a write that was actually selected.
    assign commit_c = wr_s2_q && !wr_s3_q && active_seen_q;

    // Synchronisers, write capture and all state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_s1_q       <= 1'b1;
            wr_s2_q       <= 1'b1;
            wr_s3_q       <= 1'b1;
            cs_s1_q       <= 1'b1;
            cs_s2_q       <= 1'b1;
            active_seen_q <= 1'b0;
            d_q           <= '0;
            icw_q         <= '0;
            ocw_q         <= '0;
            state_q       <= UNINIT;
            ltim_q        <= 1'b0;
            sngl_q        <= 1'b0;
            ic4_q         <= 1'b0;
            vector_base_q <= '0;
            cascade_q     <= '0;
            upm_q         <= 1'b0;
            aeoi_q        <= 1'b0;
            buf_q         <= 1'b0;
            ms_q          <= 1'b0;
            sfnm_q        <= 1'b0;
            imr_q         <= '0;
            ocw2_cmd_q    <= '0;
            ocw2_level_q  <= '0;
            ocw2_stb_q    <= 1'b0;
            ris_q         <= 1'b0;
            smm_q         <= 1'b0;
            poll_stb_q    <= 1'b0;
        end else begin
            wr_s1_q <= WR;
            wr_s2_q <= wr_s1_q;
            wr_s3_q <= wr_s2_q;
            cs_s1_q <= CS;
            cs_s2_q <= cs_s1_q;
            // Last sample taken while the write is active wins.
            if (active_c) begin
                d_q           <= D;
                icw_q         <= ICW;
                ocw_q         <= OCW;
                active_seen_q <= 1'b1;
            end else if (commit_c) begin
                active_seen_q <= 1'b0;
            end
            state_q       <= state_d;
            ltim_q        <= ltim_d;
            sngl_q        <= sngl_d;
            ic4_q         <= ic4_d;
            vector_base_q <= vector_base_d;
            cascade_q     <= cascade_d;
            upm_q         <= upm_d;
            aeoi_q        <= aeoi_d;
            buf_q         <= buf_d;
            ms_q          <= ms_d;
            sfnm_q        <= sfnm_d;
            imr_q         <= imr_d;
            ocw2_cmd_q    <= ocw2_cmd_d;
            ocw2_level_q  <= ocw2_level_d;
            ocw2_stb_q    <= ocw2_stb_d;
            ris_q         <= ris_d;
            smm_q         <= smm_d;
            poll_stb_q    <= poll_stb_d;
        end
    end

    // Next-state and register updates for a committed write.
    always_comb begin
        state_d       = state_q;
        ltim_d        = ltim_q;
        sngl_d        = sngl_q;
        ic4_d         = ic4_q;
        vector_base_d = vector_base_q;
        cascade_d     = cascade_q;
        upm_d         = upm_q;
        aeoi_d        = aeoi_q;
        buf_d         = buf_q;
        ms_d          = ms_q;
        sfnm_d        = sfnm_q;
        imr_d         = imr_q;
        ocw2_cmd_d    = ocw2_cmd_q;
        ocw2_level_d  = ocw2_level_q;
        ocw2_stb_d    = 1'b0;
        ris_d         = ris_q;
        smm_d         = smm_q;
        poll_stb_d    = 1'b0;

        if (commit_c) begin
            if (icw_q[0]) begin
                // ICW1 restarts initialisation from any state.
                ltim_d    = d_q[3];
                sngl_d    = d_q[1];
                ic4_d     = d_q[0];
                cascade_d = '0;
                upm_d     = 1'b0;
                aeoi_d    = 1'b0;
                buf_d     = 1'b0;
                ms_d      = 1'b0;
                sfnm_d    = 1'b0;
                imr_d     = '0;
                ris_d     = 1'b0;
                smm_d     = 1'b0;
                state_d   = WAIT_ICW2;
            end else begin
                case (state_q)
                    WAIT_ICW2: if (icw_q[1]) begin
                        vector_base_d = d_q[7:3];
                        if (!sngl_q)    state_d = WAIT_ICW3;
                        else if (ic4_q) state_d = WAIT_ICW4;
                        else            state_d = READY;
                    end
                    WAIT_ICW3: if (icw_q[1]) begin
                        cascade_d = d_q;
                        state_d   = ic4_q ? WAIT_ICW4 : READY;
                    end
                    WAIT_ICW4: if (icw_q[1]) begin
                        upm_d   = d_q[0];
                        aeoi_d  = d_q[1];
                        ms_d    = d_q[2];
                        buf_d   = d_q[3];
                        sfnm_d  = d_q[4];
                        state_d = READY;
                    end
                    READY: begin
                        if (ocw_q[0]) imr_d = d_q;
                        if (ocw_q[1]) begin
                            ocw2_cmd_d   = d_q[7:5];
                            ocw2_level_d = d_q[2:0];
                            ocw2_stb_d   = 1'b1;
                        end
                        if (ocw_q[2]) begin
                            if (d_q[1]) ris_d = d_q[0];
                            if (d_q[6]) smm_d = d_q[5];
                            if (d_q[2]) poll_stb_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ready       = (state_q == READY);
    assign ltim        = ltim_q;
    assign sngl        = sngl_q;
    assign ic4         = ic4_q;
    assign vector_base = vector_base_q;
    assign cascade     = cascade_q;
    assign upm         = upm_q;
    assign aeoi        = aeoi_q;
    assign buf_mode    = buf_q;
    assign ms          = ms_q;
    assign sfnm        = sfnm_q;
    assign imr         = imr_q;
    assign ocw2_cmd    = ocw2_cmd_q;
    assign ocw2_level  = ocw2_level_q;
    assign ocw2_stb    = ocw2_stb_q;
    assign ris         = ris_q;
    assign smm         = smm_q;
    assign poll_stb    = poll_stb_q;

endmodule

// File: tb/tb_pic_init_control.sv
// Testbench for pic_init_control: directed init/OCW sequences followed by
// randomized bus writes, checked against a behavioural register model.
module tb_pic_init_control;

    logic       clk = 1'b0;
    logic       rst_n, WR, CS;
    logic [7:0] D;
    logic [1:0] ICW;
    logic [2:0] OCW;
    logic       ready, ltim, sngl, ic4;
    logic [4:0] vector_base;
    logic [7:0] cascade, imr;
    logic       upm, aeoi, buf_mode, ms, sfnm;
    logic [2:0] ocw2_cmd, ocw2_level;
    logic       ocw2_stb, ris, smm, poll_stb;

    pic_init_control dut (
        .clk(clk), .rst_n(rst_n), .WR(WR), .CS(CS), .D(D), .ICW(ICW), .OCW(OCW),
        .ready(ready), .ltim(ltim), .sngl(sngl), .ic4(ic4),
        .vector_base(vector_base), .cascade(cascade),
        .upm(upm), .aeoi(aeoi), .buf_mode(buf_mode), .ms(ms), .sfnm(sfnm),
        .imr(imr), .ocw2_cmd(ocw2_cmd), .ocw2_level(ocw2_level), .ocw2_stb(ocw2_stb),
        .ris(ris), .smm(smm), .poll_stb(poll_stb)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int ocw2_cnt = 0;
    int poll_cnt = 0;

    // Strobe cycle counters; a correct pulse adds exactly one per command.
    always @(negedge clk) begin
        if (ocw2_stb) ocw2_cnt++;
        if (poll_stb) poll_cnt++;
    end

    // Reference model: stage 0=uninit,1=want ICW2,2=want ICW3,3=want ICW4,4=ready.
    int         m_stage;
    logic       m_ltim, m_sngl, m_ic4, m_ris, m_smm;
    logic [4:0] m_vb, m_icw4;
    logic [7:0] m_cas, m_imr;
    logic [2:0] m_cmd, m_lvl;
    int         e_o2, e_poll;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stage = 0; m_ltim = 0; m_sngl = 0; m_ic4 = 0; m_ris = 0; m_smm = 0;
        m_vb = 0; m_icw4 = 0; m_cas = 0; m_imr = 0; m_cmd = 0; m_lvl = 0;
    endtask

    task automatic model_write(input logic a0, input logic [7:0] d, input logic cs_n);
        e_o2 = 0;
        e_poll = 0;
        if (cs_n) return;
        if (!a0 && d[4]) begin
            m_ltim = d[3]; m_sngl = d[1]; m_ic4 = d[0];
            m_cas = 0; m_icw4 = 0; m_imr = 0; m_ris = 0; m_smm = 0;
            m_stage = 1;
        end else if (m_stage == 1 && a0) begin
            m_vb = d[7:3];
            m_stage = !m_sngl ? 2 : (m_ic4 ? 3 : 4);
        end else if (m_stage == 2 && a0) begin
            m_cas = d;
            m_stage = m_ic4 ? 3 : 4;
        end else if (m_stage == 3 && a0) begin
            m_icw4 = d[4:0];
            m_stage = 4;
        end else if (m_stage == 4) begin
            if (a0) m_imr = d;
            else if (!d[4] && !d[3]) begin
                m_cmd = d[7:5]; m_lvl = d[2:0]; e_o2 = 1;
            end else if (!d[4] && d[3]) begin
                if (d[1]) m_ris = d[0];
                if (d[6]) m_smm = d[5];
                if (d[2]) e_poll = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ready"},       32'(ready), 32'(m_stage == 4));
        check({tag, ".icw1"},        32'({ltim, sngl, ic4}), 32'({m_ltim, m_sngl, m_ic4}));
        check({tag, ".vector_base"}, 32'(vector_base), 32'(m_vb));
        check({tag, ".cascade"},     32'(cascade), 32'(m_cas));
        check({tag, ".icw4"},        32'({sfnm, buf_mode, ms, aeoi, upm}), 32'(m_icw4));
        check({tag, ".imr"},         32'(imr), 32'(m_imr));
        check({tag, ".ocw2"},        32'({ocw2_cmd, ocw2_level}), 32'({m_cmd, m_lvl}));
        check({tag, ".ris_smm"},     32'({ris, smm}), 32'({m_ris, m_smm}));
    endtask

    // One CPU write as the bus plus data_read decoder would present it.
    task automatic do_write(input string tag, input logic a0, input logic [7:0] d,
                            input logic cs_n, input int low);
        int o2, p0;
        o2 = ocw2_cnt;
        p0 = poll_cnt;
        @(negedge clk);
        D   = d;
        ICW = {a0, !a0 && d[4]};
        OCW = {!a0 && !d[4] && d[3], !a0 && !d[4] && !d[3], a0};
        CS  = cs_n;
        WR  = 1'b0;
        repeat (low) @(negedge clk);
        WR = 1'b1;
        repeat (6) @(negedge clk);
        CS = 1'b1;
        model_write(a0, d, cs_n);
        check_all(tag);
        check({tag, ".ocw2_stb_cycles"}, 32'(ocw2_cnt - o2), 32'(e_o2));
        check({tag, ".poll_stb_cycles"}, 32'(poll_cnt - p0), 32'(e_poll));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        WR = 1'b1;
        CS = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        check_all(tag);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; WR = 1'b1; CS = 1'b1; D = '0; ICW = '0; OCW = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        // Single mode, no ICW4.
        do_write("s_icw1", 1'b0, 8'h12, 1'b0, 2);
        do_write("s_icw2", 1'b1, 8'h48, 1'b0, 2);
        // Cascade with ICW4.
        do_write("c_icw1", 1'b0, 8'h11, 1'b0, 3);
        do_write("c_icw2", 1'b1, 8'h20, 1'b0, 2);
        do_write("c_icw3", 1'b1, 8'h04, 1'b0, 2);
        do_write("c_icw4", 1'b1, 8'h03, 1'b0, 4);
        // OCWs in READY.
        do_write("ocw1",   1'b1, 8'hA5, 1'b0, 2);
        do_write("ocw2_a", 1'b0, 8'h63, 1'b0, 2);
        do_write("ocw2_b", 1'b0, 8'h20, 1'b0, 2);
        do_write("ocw3_rr", 1'b0, 8'h0B, 1'b0, 2);
        do_write("ocw3_p", 1'b0, 8'h0C, 1'b0, 3);
        do_write("cs_high", 1'b0, 8'h12, 1'b1, 3);
        // Re-initialisation with early OCW2.
        do_write("ocw1_ff", 1'b1, 8'hFF, 1'b0, 2);
        do_write("reinit",  1'b0, 8'h13, 1'b0, 2);
        do_write("early_ocw2", 1'b0, 8'h63, 1'b0, 2);
        do_write("r_icw2", 1'b1, 8'hF8, 1'b0, 2);
        do_write("r_icw3", 1'b1, 8'h80, 1'b0, 2);
        do_write("r_icw4", 1'b1, 8'h1D, 1'b0, 2);
        // Reset mid-sequence, then a stray A0=1 write.
        do_write("m_icw1", 1'b0, 8'h11, 1'b0, 2);
        do_write("m_icw2", 1'b1, 8'h20, 1'b0, 2);
        do_reset("mid_reset");
        do_write("after_reset", 1'b1, 8'h04, 1'b0, 2);

        // Randomized writes; ICW1 is biased so READY is reached often.
        for (int i = 0; i < 300; i++) begin
            int r;
            logic a0, cs_n;
            logic [7:0] d;
            r    = int'($urandom_range(0, 99));
            a0   = 1'($urandom_range(0, 1));
            d    = 8'($urandom);
            cs_n = ($urandom_range(0, 9) == 0);
            if (r < 2) begin
                do_reset("rnd_reset");
            end else begin
                if (r < 14) begin
                    a0 = 1'b0;
                    d[4] = 1'b1;
                end
                do_write("rnd", a0, d, cs_n, int'($urandom_range(2, 4)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
